seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Serial receiver for the team's fixed 32-bit repeating binary test sequence; the other end of the sequence-generator link.
- Hunts for frame alignment, locks onto it, then checks every received bit against the expected pattern bit.
- Reports lock status, frame boundaries and bit errors.
- Sits at the board input (or on an internal loopback) to verify the generator output and the link.

Parameters:
- ERR_THRESH, 3: maximum bit errors tolerated within one 32-bit frame; more than this drops lock.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  received serial bit.
- din_en  input  1  din is valid this cycle; when low, all state holds.
- clr  input  1  synchronous clear of err_cnt.
- locked  output  1  frame alignment held.
- frame_start  output  1  one-cycle pulse on the edge that accepts a frame's position-0 alignment (lock edge and every wrap while locked).
- err_pulse  output  1  one-cycle pulse for a mismatched bit while locked.
- err_cnt  output  CNT_W  total mismatched bits, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async, rst_n=0):
  - state=HUNT, shift register=0, fill=0, phase=0, frame_err=0.
  - locked=0, frame_start=0, err_pulse=0, err_cnt=0.
  - Takes effect immediately, including mid-lock.
- Pattern:
  - PATTERN = 32'h3DB5_3C3C. Bit i is the sequence bit at position i; position 0 is transmitted first.
  - Sequence by position: 0011 1100 0011 1100 1010 1101 1011 1100.
- Shift register:
  - On each din_en: sr <= {din, sr[31:1]}, so sr[0] holds the oldest bit.
  - fill counts up to 32 and saturates.
- State HUNT:
  - Compute sr_next = {din, sr[31:1]}.
  - If din_en, fill >= 31 and sr_next == PATTERN, then on that same edge: state=LOCKED, phase=0, frame_err=0, locked=1, frame_start=1.
  - Latency 0: lock is visible on the edge after the position-31 bit is sampled.
  - err_pulse stays 0 in HUNT, and err_cnt does not change.
- State LOCKED, on each din_en:
  - exp = PATTERN[phase]. If din != exp: err_pulse=1, err_cnt+1 (saturates at all-ones), frame_err+1.
  - phase increments and wraps 31 -> 0.
  - At phase==31, let total = frame_err including this bit.
  - If total > ERR_THRESH: state=HUNT, locked=0, fill=0, frame_start=0.
  - Otherwise frame_start=1, frame_err=0, and lock is kept.
- Registered pulses: frame_start and err_pulse are registered and high for exactly one cycle. They are 0 on every din_en=0 cycle.
- clr: err_cnt <= 0. clr wins over a simultaneous error (err_cnt=0, err_pulse still 1). clr does not affect lock.
- Loss of lock: fill restarts at 0, so relock needs at least 32 fresh bits.
- Alignment uniqueness: no nonzero rotation of PATTERN equals PATTERN. The bench confirms this exhaustively at elaboration.
- Widths:
  - phase is 5 bits and wraps naturally.
  - fill is 6 bits.
  - frame_err is 6 bits; it cannot overflow because it resets every frame.

Decomposition:
- Shared package seq_pkg holds:
  - SEQ_LEN = 32
  - SEQ_PATTERN = 32'h3DB5_3C3C
  - state enum {HUNT, LOCKED}
- The generator is to be re-pointed to SEQ_PATTERN so both ends share one definition.
- One natural sub-module: sat_counter (width parameter, inc, clr, clr priority), used for err_cnt.

Test Plan:
- Reset, then 32 bits of positions 0..31 with din_en=1 -> locked=1 and frame_start=1 on the 32nd edge; no err_pulse; err_cnt=0.
- Continuous stream starting at position 5 -> no lock for 58 bits; locked=1 with frame_start on the 59th bit; frame_start thereafter every 32 bits.
- Locked, invert the bit at phase 10 -> err_pulse for exactly one cycle, err_cnt=1, locked stays 1, next frame_start on time.
- Locked, invert 4 bits in one frame (ERR_THRESH=3) -> err_cnt=4, locked falls at the phase-31 edge with no frame_start; a clean stream then relocks in 32..63 bits.
- Locked with din_en toggling 1010 -> phase advances only on din_en=1 cycles; pulses never appear on din_en=0 cycles. Then assert clr together with an error -> err_cnt=0 and err_pulse=1.
- CNT_W=4, 3 errors per frame for 6 frames -> err_cnt saturates at 15 and lock is held. Then rst_n=0 mid-frame -> all outputs 0 asynchronously, and relock requires 32 bits.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 32-bit repeating test sequence, used by both the
// generator and the checker so the two ends cannot drift apart.
package seq_pkg;

   localparam int SEQ_LEN = 32;

   // Bit i is the sequence bit at position i; position 0 goes on the wire first.
   localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 32'h3DB5_3C3C;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over the
// increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seq_checker.sv
// Receiver for the repeating test sequence: hunts for frame alignment, then
// checks each bit against the expected pattern and reports lock and errors.
module seq_checker
   import seq_pkg::*;
#(
   parameter int ERR_THRESH = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_en,
   input  logic             clr,
   output logic             locked,
   output logic             frame_start,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [5:0] THRESH = 6'(ERR_THRESH);

   seq_state_e state_q, state_d;
   logic [SEQ_LEN-1:0] sr_q, sr_d, sr_next;
   logic [5:0] fill_q, fill_d;
   logic [4:0] phase_q, phase_d;
   logic [5:0] ferr_q, ferr_d, ferr_total;
   logic       fs_q, fs_d;
   logic       ep_q, ep_d;
   logic       mismatch;
   logic       err_inc;

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      fill_d     = fill_q;
      phase_d    = phase_q;
      ferr_d     = ferr_q;
      fs_d       = 1'b0;
      ep_d       = 1'b0;
      err_inc    = 1'b0;
      sr_next    = {din, sr_q[SEQ_LEN-1:1]};
      mismatch   = (din != SEQ_PATTERN[phase_q]);
      ferr_total = ferr_q + {5'b0, mismatch};

      if (din_en) begin
         sr_d = sr_next;
         if (fill_q != 6'd32) begin
            fill_d = fill_q + 6'd1;
         end
         case (state_q)
            HUNT: begin
               // The bit arriving now completes the window, so lock on this edge.
               if ((fill_q >= 6'd31) && (sr_next == SEQ_PATTERN)) begin
                  state_d = LOCKED;
                  phase_d = 5'd0;
                  ferr_d  = 6'd0;
                  fs_d    = 1'b1;
               end
            end
            LOCKED: begin
               ep_d    = mismatch;
               err_inc = mismatch;
               ferr_d  = ferr_total;
               phase_d = phase_q + 5'd1;
               if (phase_q == 5'd31) begin
                  if (ferr_total > THRESH) begin
                     // Fresh fill forces a full 32-bit window before relock.
                     state_d = HUNT;
                     fill_d  = 6'd0;
                  end else begin
                     fs_d   = 1'b1;
                     ferr_d = 6'd0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         sr_q    <= '0;
         fill_q  <= 6'd0;
         phase_q <= 5'd0;
         ferr_q  <= 6'd0;
         fs_q    <= 1'b0;
         ep_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         fill_q  <= fill_d;
         phase_q <= phase_d;
         ferr_q  <= ferr_d;
         fs_q    <= fs_d;
         ep_q    <= ep_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc),
      .clr   (clr),
      .cnt   (err_cnt)
   );

   assign locked      = (state_q == LOCKED);
   assign frame_start = fs_q;
   assign err_pulse   = ep_q;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: two instances (16-bit and 4-bit error counters) share
// one stimulus stream and are checked against a queue-based reference model.
module tb_seq_checker;

   localparam int ERR_THRESH = 3;
   localparam int W = 23;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic din = 1'b0;
   logic din_en = 1'b0;
   logic clr = 1'b0;

   logic        locked_a, fs_a, ep_a;
   logic [15:0] cnt_a;
   logic        locked_b, fs_b, ep_b;
   logic [3:0]  cnt_b;

   seq_checker #(.ERR_THRESH(ERR_THRESH), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .clr(clr),
      .locked(locked_a), .frame_start(fs_a), .err_pulse(ep_a), .err_cnt(cnt_a)
   );

   seq_checker #(.ERR_THRESH(ERR_THRESH), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .clr(clr),
      .locked(locked_b), .frame_start(fs_b), .err_pulse(ep_b), .err_cnt(cnt_b)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   string seq_str = "00111100001111001010110110111100";
   bit    seq_bit[32];

   logic [W-1:0] exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   bit    m_locked;
   int    m_phase;
   int    m_ferr;
   int    m_cnt;
   bit    m_hist[$];
   int    tx_pos = 0;

   function automatic bit hist_aligned();
      if (m_hist.size() != 32) return 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (m_hist[i] != seq_bit[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_locked = 1'b0;
      m_phase  = 0;
      m_ferr   = 0;
      m_cnt    = 0;
      m_hist.delete();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit b, input bit en, input bit c);
      bit fs, ep;
      logic [15:0] c16;
      logic [3:0]  c4;
      @(negedge clk);
      din = b;
      din_en = en;
      clr = c;
      fs = 1'b0;
      ep = 1'b0;
      if (en) begin
         if (!m_locked) begin
            m_hist.push_back(b);
            if (m_hist.size() > 32) void'(m_hist.pop_front());
            if (hist_aligned()) begin
               m_locked = 1'b1;
               m_phase  = 0;
               m_ferr   = 0;
               fs       = 1'b1;
            end
         end else begin
            if (b != seq_bit[m_phase]) begin
               ep = 1'b1;
               m_cnt++;
               m_ferr++;
            end
            if (m_phase == 31) begin
               if (m_ferr > ERR_THRESH) begin
                  m_locked = 1'b0;
                  m_hist.delete();
               end else begin
                  fs = 1'b1;
                  m_ferr = 0;
               end
            end
            m_phase = (m_phase + 1) % 32;
         end
      end
      if (c) m_cnt = 0;
      c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      c4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
      exp_q.push_back({m_locked, fs, ep, c16, c4});
   endtask

   // Sends the next stream bit (optionally inverted); idle cycles carry noise.
   task automatic send(input bit flip, input bit en, input bit c);
      bit b;
      if (en) begin
         b = seq_bit[tx_pos] ^ flip;
         tx_pos = (tx_pos + 1) % 32;
      end else begin
         b = 1'($urandom_range(0, 1));
      end
      step(b, en, c);
   endtask

   task automatic drain();
      int k;
      @(negedge clk);
      din_en = 1'b0;
      clr = 1'b0;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk("drain_queue_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_locked_a"}, locked_a, 0);
      chk({tag, "_fs_a"},     fs_a, 0);
      chk({tag, "_ep_a"},     ep_a, 0);
      chk({tag, "_cnt_a"},    cnt_a, 0);
      chk({tag, "_locked_b"}, locked_b, 0);
      chk({tag, "_fs_b"},     fs_b, 0);
      chk({tag, "_ep_b"},     ep_b, 0);
      chk({tag, "_cnt_b"},    cnt_b, 0);
   endtask

   // Asynchronous reset applied between clock edges.
   task automatic async_reset(input string tag);
      drain();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("locked_a",      locked_a, e[22]);
            chk("frame_start_a", fs_a,     e[21]);
            chk("err_pulse_a",   ep_a,     e[20]);
            chk("err_cnt_a",     cnt_a,    e[19:4]);
            chk("locked_b",      locked_b, e[22]);
            chk("frame_start_b", fs_b,     e[21]);
            chk("err_pulse_b",   ep_b,     e[20]);
            chk("err_cnt_b",     cnt_b,    e[3:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r;
      bit same;

      for (int i = 0; i < 32; i++) seq_bit[i] = (seq_str[i] == 8'h31);
      for (int rot = 1; rot < 32; rot++) begin
         same = 1'b1;
         for (int i = 0; i < 32; i++) begin
            if (seq_bit[i] != seq_bit[(i + rot) % 32]) same = 1'b0;
         end
         if (same) begin
            $display("FAIL rotation_unique: rotation %0d equals the pattern", rot);
            $fatal(1, "pattern not rotation-unique");
         end
      end

      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean frame from position 0, then a second frame.
      tx_pos = 0;
      for (int i = 0; i < 64; i++) send(1'b0, 1'b1, 1'b0);

      // Stream starting at position 5.
      async_reset("reset_mid_lock1");
      tx_pos = 5;
      for (int i = 0; i < 27 + 32 + 64; i++) send(1'b0, 1'b1, 1'b0);

      // Single error at phase 10.
      while (tx_pos != 0) send(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 64; i++) send(tx_pos == 10, 1'b1, 1'b0);

      // Four errors in one frame drops lock, clean stream relocks.
      r = $urandom_range(0, 10);
      for (int i = 0; i < 32; i++)
         send((i == r) || (i == r + 7) || (i == r + 14) || (i == r + 21), 1'b1, 1'b0);
      for (int i = 0; i < 70; i++) send(1'b0, 1'b1, 1'b0);

      // din_en toggling while locked, then clr with a simultaneous error.
      for (int i = 0; i < 64; i++) send(1'b0, (i % 2) == 0, 1'b0);
      send(1'b1, 1'b1, 1'b1);
      send(1'b0, 1'b1, 1'b0);

      // Three errors per frame for six frames; 4-bit counter saturates.
      while (tx_pos != 0) send(1'b0, 1'b1, 1'b0);
      for (int f = 0; f < 6; f++) begin
         r = $urandom_range(0, 9);
         for (int i = 0; i < 32; i++)
            send((i == r) || (i == r + 10) || (i == r + 20), 1'b1, 1'b0);
      end
      for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 1'b0);
      async_reset("reset_mid_lock2");
      tx_pos = 0;
      for (int i = 0; i < 40; i++) send(1'b0, 1'b1, 1'b0);

      // Random traffic: gaps, sparse errors, occasional clears and slips.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) tx_pos = (tx_pos + 1) % 32;
         send($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 99) == 0);
      end

      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
